// File: rtl/insmem_pkg.sv
// Shared types and sizing helpers for the loadable instruction memory.
package insmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int waddr_w(int pc_bits, int addr_lsb);
    return pc_bits - addr_lsb;
  endfunction

  function automatic int depth_f(int pc_bits, int addr_lsb);
    return 1 << waddr_w(pc_bits, addr_lsb);
  endfunction

endpackage

// File: rtl/insmem_ram.sv
// Single-port synchronous RAM; a read holds rdata until the next read.
module insmem_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 5
) (
  input  logic              clka,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clka) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/insmem_loader.sv
// Instruction memory with registered fetch and a streaming program loader.
module insmem_loader
  import insmem_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PC_BITS  = 6,
  parameter int ADDR_LSB = 1,
  parameter int CNT_W    = PC_BITS - ADDR_LSB + 1
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic [PC_BITS-1:0] pc,
  output logic [DATA_W-1:0]  instr_out,
  output logic               instr_valid,
  input  logic               load_start,
  input  logic [PC_BITS-1:0] load_base,
  input  logic [CNT_W-1:0]   load_count,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_valid,
  output logic               load_ready,
  output logic               busy,
  output logic               load_done,
  output logic               load_err
);

  localparam int AW = waddr_w(PC_BITS, ADDR_LSB);
  localparam logic [CNT_W-1:0] DEPTH_C =
    CNT_W'(depth_f(PC_BITS, ADDR_LSB));

  state_t            state;
  logic [AW-1:0]     wr_addr;
  logic [CNT_W-1:0]  remaining;
  logic              clr;
  logic              we;
  logic              en;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] rdata;
  logic              unused_bits;

  assign unused_bits = ^{pc[ADDR_LSB-1:0], load_base[ADDR_LSB-1:0]};

  assign load_ready = (state == LOAD);
  assign busy       = (state != IDLE);
  assign we         = load_ready & load_valid;
  assign en         = we | ((state == IDLE) & fetch_en);
  assign addr       = load_ready ? wr_addr : pc[PC_BITS-1:ADDR_LSB];
  // clr masks the held RAM read after a load or reset
  assign instr_out  = clr ? '0 : rdata;

  insmem_ram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clka  (clka),
    .en    (en),
    .we    (we),
    .addr  (addr),
    .wdata (load_data),
    .rdata (rdata)
  );

  always_ff @(posedge clka) begin
    if (rst) begin
      state       <= IDLE;
      wr_addr     <= '0;
      remaining   <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      instr_valid <= 1'b0;
      clr         <= 1'b1;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          instr_valid <= fetch_en;
          if (fetch_en) clr <= 1'b0;
          if (load_start) begin
            if (load_count == '0) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else if (load_count > DEPTH_C) begin
              load_err <= 1'b1;
            end else begin
              state     <= LOAD;
              wr_addr   <= load_base[PC_BITS-1:ADDR_LSB];
              remaining <= load_count;
            end
          end
        end
        LOAD: begin
          instr_valid <= 1'b0;
          clr         <= 1'b1;
          if (load_valid) begin
            wr_addr   <= wr_addr + AW'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state     <= DONE;
              load_done <= 1'b1;
            end
          end
        end
        DONE: begin
          instr_valid <= 1'b0;
          clr         <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insmem_loader.sv
// Directed bench: vector table for fetches plus load corner sequences.
module tb_insmem_loader;

  logic        clka = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [5:0]  pc;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        load_start;
  logic [5:0]  load_base;
  logic [5:0]  load_count;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        fen;
    logic [5:0]  pc;
    logic        exp_valid;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t tbl[10];

  insmem_loader dut (
    .clka        (clka),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_count  (load_count),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .busy        (busy),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fetch_chk(string name, logic [5:0] a, logic [15:0] exp);
    fetch_en = 1'b1;
    pc = a;
    tick();
    fetch_en = 1'b0;
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
    chk(name, 32'(instr_out), 32'(exp));
  endtask

  // Unstalled load of cnt words, data d0+i; checks done latency.
  task automatic load_run(string name, logic [5:0] base, int cnt,
                          logic [15:0] d0);
    int n;
    int i;
    load_base = base;
    load_count = 6'(cnt);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n = 1;
    i = 0;
    while (!load_done && n < cnt + 8) begin
      load_valid = load_ready;
      load_data = d0 + 16'(i);
      tick();
      if (load_valid) i++;
      n++;
    end
    load_valid = 1'b0;
    chk({name, "_latency"}, 32'(n), 32'(cnt + 1));
    chk({name, "_words"}, 32'(i), 32'(cnt));
    tick();
    chk({name, "_done_drop"}, 32'(load_done), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    pc = '0;
    load_start = 1'b0;
    load_base = '0;
    load_count = '0;
    load_data = '0;
    load_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);

    fetch_en = 1'b1;
    pc = 6'h00;
    tick();
    fetch_en = 1'b0;
    chk("uninit_fetch_valid", 32'(instr_valid), 32'd1);

    // Full array: word i = 0x5000+i
    load_run("full", 6'h00, 32, 16'h5000);
    load_run("basic", 6'h04, 3, 16'hA001);

    tbl[0] = '{1'b1, 6'h04, 1'b1, 16'hA001};
    tbl[1] = '{1'b1, 6'h06, 1'b1, 16'hA002};
    tbl[2] = '{1'b1, 6'h08, 1'b1, 16'hA003};
    tbl[3] = '{1'b1, 6'h05, 1'b1, 16'hA001};
    tbl[4] = '{1'b0, 6'h00, 1'b0, 16'hA001};
    tbl[5] = '{1'b1, 6'h00, 1'b1, 16'h5000};
    tbl[6] = '{1'b1, 6'h0A, 1'b1, 16'h5005};
    tbl[7] = '{1'b1, 6'h3E, 1'b1, 16'h501F};
    tbl[8] = '{1'b1, 6'h3F, 1'b1, 16'h501F};
    tbl[9] = '{1'b1, 6'h02, 1'b1, 16'h5001};
    for (int k = 0; k < 10; k++) begin
      fetch_en = tbl[k].fen;
      pc = tbl[k].pc;
      tick();
      chk($sformatf("vec%0d_valid", k), 32'(instr_valid),
          32'(tbl[k].exp_valid));
      chk($sformatf("vec%0d_instr", k), 32'(instr_out),
          32'(tbl[k].exp_instr));
    end
    fetch_en = 1'b0;

    // Stall and wrap
    load_base = 6'h3E;
    load_count = 6'd2;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("wrap_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data = 16'hC031;
    tick();
    load_valid = 1'b0;
    chk("wrap_nodone1", 32'(load_done), 32'd0);
    tick();
    tick();
    chk("wrap_stall_ready", 32'(load_ready), 32'd1);
    chk("wrap_stall_busy", 32'(busy), 32'd1);
    load_valid = 1'b1;
    load_data = 16'hC000;
    tick();
    load_valid = 1'b0;
    chk("wrap_done", 32'(load_done), 32'd1);
    tick();
    fetch_chk("wrap_w31", 6'h3E, 16'hC031);
    fetch_chk("wrap_w0", 6'h00, 16'hC000);
    fetch_chk("wrap_w1", 6'h02, 16'h5001);

    // Zero count
    load_count = 6'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("zero_done", 32'(load_done), 32'd1);
    chk("zero_ready", 32'(load_ready), 32'd0);
    tick();
    chk("zero_done_drop", 32'(load_done), 32'd0);
    chk("zero_idle", 32'(busy), 32'd0);
    fetch_chk("zero_mem", 6'h02, 16'h5001);

    // Oversize count
    load_count = 6'd33;
    load_base = 6'h00;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("over_err", 32'(load_err), 32'd1);
    chk("over_busy", 32'(busy), 32'd0);
    chk("over_ready", 32'(load_ready), 32'd0);
    tick();
    chk("over_err_drop", 32'(load_err), 32'd0);
    chk("over_nodone", 32'(load_done), 32'd0);
    fetch_chk("over_mem", 6'h00, 16'hC000);

    // Collision: fetch served from pre-load contents
    load_base = 6'h04;
    load_count = 6'd1;
    load_start = 1'b1;
    fetch_en = 1'b1;
    pc = 6'h04;
    tick();
    load_start = 1'b0;
    chk("coll_instr", 32'(instr_out), 32'hA001);
    chk("coll_valid", 32'(instr_valid), 32'd1);
    chk("coll_busy", 32'(busy), 32'd1);
    load_valid = 1'b1;
    load_data = 16'hBEEF;
    tick();
    load_valid = 1'b0;
    chk("coll_load_valid", 32'(instr_valid), 32'd0);
    chk("coll_load_instr", 32'(instr_out), 32'd0);
    chk("coll_done", 32'(load_done), 32'd1);
    fetch_en = 1'b0;
    tick();
    chk("coll_after_instr", 32'(instr_out), 32'd0);
    fetch_chk("coll_new", 6'h04, 16'hBEEF);

    // Reset mid-load
    load_base = 6'h10;
    load_count = 6'd5;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 16'hD001;
    tick();
    load_data = 16'hD002;
    tick();
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(load_done), 32'd0);
    chk("abort_ready", 32'(load_ready), 32'd0);
    chk("abort_instr", 32'(instr_out), 32'd0);
    tick();
    chk("abort_done_later", 32'(load_done), 32'd0);
    fetch_chk("abort_w8", 6'h10, 16'hD001);
    fetch_chk("abort_w9", 6'h12, 16'hD002);
    fetch_chk("abort_w10", 6'h14, 16'h500A);
    fetch_chk("abort_w11", 6'h16, 16'h500B);
    fetch_chk("abort_w12", 6'h18, 16'h500C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
